// File: rtl/gift_sbox_share_compress.sv
// Register-and-compress stage behind the 3-share GIFT S-box component functions.
// Stage 1 latches the raw partial terms as a glitch barrier; stage 2 folds them into 3 shares.
module gift_sbox_share_compress #(
    parameter int N_COORD = 4,
    parameter int N_TERM  = 9,
    parameter bit REFRESH = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_COORD*N_TERM-1:0]   in_terms,
    input  logic [2*N_COORD-1:0]        in_rand,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_COORD-1:0]          out_s1,
    output logic [N_COORD-1:0]          out_s2,
    output logic [N_COORD-1:0]          out_s3,
    output logic [1:0]                  occupancy
);

    localparam int GRP = N_TERM / 3;

    logic [N_COORD*N_TERM-1:0] t1_q;
    logic [2*N_COORD-1:0]      r1_q;
    logic                      v1_q;
    logic                      v2_q;
    logic [N_COORD-1:0]        s1_q;
    logic [N_COORD-1:0]        s2_q;
    logic [N_COORD-1:0]        s3_q;

    logic                      ready2;
    logic                      ld1;
    logic                      ld2;
    logic [2*N_COORD-1:0]      rnd_eff;
    logic [N_COORD-1:0]        g0, g1, g2;
    logic [N_COORD-1:0]        r0v, r1v;
    logic [N_COORD-1:0]        n1, n2, n3;

    // Handshake: a beat moves across a boundary on a rising edge where valid & ready are both
    // high; valid never depends on ready, and flush blocks every load while clearing both valids.
    assign ready2   = !v2_q || out_ready;
    assign in_ready = !flush && (!v1_q || ready2);
    assign ld1      = in_valid && in_ready;
    assign ld2      = v1_q && ready2 && !flush;

    assign rnd_eff = REFRESH ? r1_q : '0;

    for (genvar c = 0; c < N_COORD; c++) begin : g_coord
        assign g0[c]  = ^t1_q[c*N_TERM         +: GRP];
        assign g1[c]  = ^t1_q[c*N_TERM + GRP   +: GRP];
        assign g2[c]  = ^t1_q[c*N_TERM + 2*GRP +: GRP];
        assign r0v[c] = rnd_eff[2*c];
        assign r1v[c] = rnd_eff[2*c+1];
    end

    // r0/r1 each enter two shares, so they cancel in s1^s2^s3.
    assign n1 = g0 ^ r0v;
    assign n2 = g1 ^ r1v;
    assign n3 = g2 ^ r0v ^ r1v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else if (flush) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            if (ld1) begin
                v1_q <= 1'b1;
            end else if (ld2) begin
                v1_q <= 1'b0;
            end
            if (ld2) begin
                v2_q <= 1'b1;
            end else if (v2_q && out_ready) begin
                v2_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1_q <= '0;
            r1_q <= '0;
        end else if (ld1) begin
            t1_q <= in_terms;
            r1_q <= in_rand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else if (ld2) begin
            s1_q <= n1;
            s2_q <= n2;
            s3_q <= n3;
        end
    end

    assign out_valid = v2_q;
    assign out_s1    = s1_q;
    assign out_s2    = s2_q;
    assign out_s3    = s3_q;
    assign occupancy = {1'b0, v1_q} + {1'b0, v2_q};

endmodule

// File: tb/tb_gift_sbox_share_compress.sv
// Bench for gift_sbox_share_compress: one plain-XOR and one refreshing instance share the
// same stimulus; a hand-computed vector table, directed handshake sequences and a random run.
module tb_gift_sbox_share_compress;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [35:0] in_terms;
    logic [7:0]  in_rand;

    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [3:0]  s1_0, s2_0, s3_0, s1_1, s2_1, s3_1;
    logic [1:0]  occupancy0, occupancy1;

    gift_sbox_share_compress #(.N_COORD(4), .N_TERM(9), .REFRESH(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_terms(in_terms), .in_rand(in_rand), .out_valid(out_valid0), .out_ready(out_ready),
        .out_s1(s1_0), .out_s2(s2_0), .out_s3(s3_0), .occupancy(occupancy0)
    );

    gift_sbox_share_compress #(.N_COORD(4), .N_TERM(9), .REFRESH(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_terms(in_terms), .in_rand(in_rand), .out_valid(out_valid1), .out_ready(out_ready),
        .out_s1(s1_1), .out_s2(s2_1), .out_s3(s3_1), .occupancy(occupancy1)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [23:0] exp_q[$];
    logic [23:0] cur_exp;
    logic [23:0] mon_e;
    bit          rand_bp;

    typedef struct {
        logic [35:0] terms;
        logic [7:0]  rnd;
        logic [11:0] p;   // {s1,s2,s3} plain compression
        logic [11:0] r;   // {s1,s2,s3} refreshed compression
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] model(input logic [35:0] t, input logic [7:0] r, input bit refresh);
        logic [3:0] a, b, d;
        logic [2:0] g;
        a = '0; b = '0; d = '0;
        for (int c = 0; c < 4; c++) begin
            g = '0;
            for (int k = 0; k < 9; k++) g[k/3] = g[k/3] ^ t[c*9+k];
            a[c] = g[0];
            b[c] = g[1];
            d[c] = g[2];
            if (refresh) begin
                a[c] = a[c] ^ r[2*c];
                b[c] = b[c] ^ r[2*c+1];
                d[c] = d[c] ^ r[2*c] ^ r[2*c+1];
            end
        end
        return {a, b, d};
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid0 && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("shares_plain", {20'd0, s1_0, s2_0, s3_0}, {20'd0, mon_e[23:12]});
                    check("shares_refresh", {20'd0, s1_1, s2_1, s3_1}, {20'd0, mon_e[11:0]});
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready0) exp_q.push_back(cur_exp);
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic [35:0] t, input logic [7:0] r, input logic [23:0] e,
                         output int waited, output logic [1:0] occ_seen);
        int k;
        bit acc;
        in_terms = t;
        in_rand  = r;
        cur_exp  = e;
        in_valid = 1'b1;
        k = 0;
        acc = 1'b0;
        occ_seen = '0;
        while (!acc && k < 200) begin
            @(negedge clk);
            if (k == 0) occ_seen = occupancy0;
            acc = in_ready0;
            if (!acc) k++;
        end
        if (!acc) check("drive_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waited = k;
    endtask

    task automatic drive_vec(input int i, output int waited, output logic [1:0] occ_seen);
        drive(tbl[i].terms, tbl[i].rnd, {tbl[i].p, tbl[i].r}, waited, occ_seen);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int          w;
        int          total_w;
        logic [1:0]  occ;
        logic [63:0] rnd64;
        logic [35:0] t;
        logic [7:0]  r;

        tbl[0] = '{36'h000000007, 8'h00, 12'h100, 12'h100};
        tbl[1] = '{36'h000000007, 8'h01, 12'h100, 12'h001};
        tbl[2] = '{36'hFFFFFFFFF, 8'hFF, 12'hFFF, 12'h00F};
        tbl[3] = '{36'h249249249, 8'h00, 12'hFFF, 12'hFFF};
        tbl[4] = '{36'h249249249, 8'hAA, 12'hFFF, 12'hF00};
        tbl[5] = '{36'h200600000, 8'h55, 12'h008, 12'hF07};
        tbl[6] = '{36'h000000400, 8'h0C, 12'h200, 12'h020};
        tbl[7] = '{36'h000000000, 8'hC0, 12'h000, 12'h880};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_terms = '0; in_rand = '0; cur_exp = '0; rand_bp = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid0", {31'd0, out_valid0}, 32'd0);
        check("rst_out_valid1", {31'd0, out_valid1}, 32'd0);
        check("rst_occupancy", {30'd0, occupancy0}, 32'd0);
        check("rst_shares", {20'd0, s1_1, s2_1, s3_1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {31'd0, in_ready0}, 32'd1);

        // latency and plain compression of coordinate 0
        drive_vec(0, w, occ);
        @(negedge clk);
        check("lat_valid_early", {31'd0, out_valid0}, 32'd0);
        check("lat_occ_one", {30'd0, occupancy0}, 32'd1);
        @(negedge clk);
        check("lat_valid", {31'd0, out_valid0}, 32'd1);
        check("lat_s1_plain", {28'd0, s1_0}, 32'd1);
        @(posedge clk);
        #1;

        // refreshed shares recombine to the term XOR
        drive_vec(1, w, occ);
        @(negedge clk);
        @(negedge clk);
        check("refresh_xor", {28'd0, s1_1 ^ s2_1 ^ s3_1}, 32'd1);
        check("refresh_s3", {28'd0, s3_1}, 32'd1);
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;

        // back-to-back table vectors at full throughput
        total_w = 0;
        for (int i = 0; i < 8; i++) begin
            drive_vec(i, w, occ);
            total_w += w;
            if (i >= 2) check("b2b_occupancy", {30'd0, occ}, 32'd2);
        end
        check("b2b_no_stall", total_w, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_drained", exp_q.size(), 32'd0);
        check("b2b_occ_zero", {30'd0, occupancy0}, 32'd0);

        // backpressure: two accepted, third held off, shares stable
        out_ready = 1'b0;
        drive_vec(2, w, occ);
        check("stall_acc0", w, 32'd0);
        drive_vec(3, w, occ);
        check("stall_acc1", w, 32'd0);
        in_terms = tbl[4].terms; in_rand = tbl[4].rnd; cur_exp = {tbl[4].p, tbl[4].r};
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready0}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid1}, 32'd1);
            check("stall_hold", {20'd0, s1_1, s2_1, s3_1}, {20'd0, tbl[2].r});
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", {31'd0, in_ready0}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("stall_drained", exp_q.size(), 32'd0);

        // flush with both stages full and a vector offered
        out_ready = 1'b0;
        drive_vec(5, w, occ);
        drive_vec(6, w, occ);
        in_terms = tbl[7].terms; in_rand = tbl[7].rnd; cur_exp = {tbl[7].p, tbl[7].r};
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", {31'd0, in_ready0}, 32'd0);
        check("flush_occ_before", {30'd0, occupancy1}, 32'd2);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", {31'd0, out_valid0}, 32'd0);
        check("flush_occ0", {30'd0, occupancy0}, 32'd0);
        check("flush_occ1", {30'd0, occupancy1}, 32'd0);
        check("flush_data_hold", {20'd0, s1_1, s2_1, s3_1}, {20'd0, tbl[5].r});
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("flush_nothing_out", {31'd0, out_valid0}, 32'd0);

        // random stream with backpressure and a reset pulse part way through
        rand_bp = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            rnd64 = {$urandom, $urandom};
            t = rnd64[35:0];
            r = 8'($urandom_range(0, 255));
            drive(t, r, {model(t, r, 1'b0), model(t, r, 1'b1)}, w, occ);
            if (n == 5000) begin
                rst_n = 1'b0;
                #1;
                check("midrst_out_valid", {31'd0, out_valid0}, 32'd0);
                check("midrst_occ0", {30'd0, occupancy0}, 32'd0);
                check("midrst_occ1", {30'd0, occupancy1}, 32'd0);
                check("midrst_shares", {20'd0, s1_1, s2_1, s3_1}, 32'd0);
                @(negedge clk);
                #1;
                rst_n = 1'b1;
                @(posedge clk);
                #2;
                check("midrst_in_ready", {31'd0, in_ready0}, 32'd1);
            end
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rand_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
